// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter that shares one uart_tx serializer among N_PORTS consoles,
// inserting a tag byte (TAG_BASE | channel) whenever the granted channel changes.
module uart_tx_arbiter #(
   parameter int         N_PORTS    = 4,
   parameter int         CH_W       = 2,
   parameter bit         TAG_ENABLE = 1'b1,
   parameter logic [7:0] TAG_BASE   = 8'hF0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_PORTS-1:0]     in_valid,
   input  logic [8*N_PORTS-1:0]   in_data,
   output logic [N_PORTS-1:0]     in_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_done,
   output logic [CH_W-1:0]        cur_chan,
   output logic                   busy
);

   typedef enum logic [2:0] {
      IDLE, TAG_GO, TAG_WLO, TAG_WHI, DAT_GO, DAT_WLO, DAT_WHI
   } state_t;

   state_t            state, next_state;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   last_chan;
   logic              last_valid;
   logic [7:0]        byte_q;

   logic              any_valid;
   logic [CH_W-1:0]   grant;
   logic [CH_W-1:0]   next_rr;
   logic [7:0]        sel_byte;
   logic              need_tag;
   logic              take;
   int                idx;

   // Search starts at rr_ptr and wraps, so the last-served port gets lowest priority.
   always_comb begin
      any_valid = 1'b0;
      grant     = '0;
      idx       = 0;
      for (int i = 0; i < N_PORTS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N_PORTS) idx = idx - N_PORTS;
         if (!any_valid && in_valid[idx[CH_W-1:0]]) begin
            any_valid = 1'b1;
            grant     = idx[CH_W-1:0];
         end
      end
   end

   always_comb begin
      sel_byte = in_data[8*int'(grant) +: 8];
      need_tag = TAG_ENABLE && (!last_valid || (grant != last_chan));
      next_rr  = (int'(grant) == N_PORTS-1) ? '0 : grant + 1'b1;
      take     = (state == IDLE) && any_valid;
   end

   // NOTE: state and data registers use non-blocking assignments so every flop
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (any_valid) next_state = need_tag ? TAG_GO : DAT_GO;
         TAG_GO:  next_state = TAG_WLO;
         TAG_WLO: if (!tx_done) next_state = TAG_WHI;
         TAG_WHI: if (tx_done)  next_state = DAT_GO;
         DAT_GO:  next_state = DAT_WLO;
         DAT_WLO: if (!tx_done) next_state = DAT_WHI;
         DAT_WHI: if (tx_done)  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      tx_start = (state == TAG_GO) || (state == DAT_GO);
      busy     = (state != IDLE);
   end

   // tx_data is loaded on entry to a *_GO state so it is already valid with tx_start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready   <= '0;
         tx_data    <= '0;
         cur_chan   <= '0;
         rr_ptr     <= '0;
         last_chan  <= '0;
         last_valid <= 1'b0;
         byte_q     <= '0;
      end else begin
         in_ready <= '0;
         if (take) begin
            in_ready[grant] <= 1'b1;
            byte_q          <= sel_byte;
            cur_chan        <= grant;
            rr_ptr          <= next_rr;
            tx_data         <= need_tag ? (TAG_BASE | 8'(grant)) : sel_byte;
         end
         if (state == TAG_WHI && tx_done) tx_data <= byte_q;
         if (state == DAT_WHI && tx_done) begin
            last_chan  <= cur_chan;
            last_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: tagged and untagged arbiter instances, each driving a behavioural
// uart_tx stand-in; a scoreboard queue holds the expected serial byte stream.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int FRAME = 200;
   localparam int LIMIT = 20000;

   typedef struct {
      int         inst;
      logic [7:0] b;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      in_valid [2];
   logic [8*N-1:0]    in_data  [2];
   logic [N-1:0]      in_ready [2];
   logic [7:0]        tx_data  [2];
   logic              tx_start [2];
   logic              tx_done  [2];
   logic [1:0]        cur_chan [2];
   logic              busy     [2];

   int                n_vec  = 0;
   int                n_miss = 0;
   exp_t              exp_q [$];
   int                gl [$];
   logic [7:0]        src_mem [2][N][16];
   int                src_wr  [2][N];
   int                src_rd  [2][N];
   logic              mbusy  [2];
   int                cnt    [2];
   int                nstart [2];
   exp_t              e;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_PORTS(N), .CH_W(2), .TAG_ENABLE(1'b1), .TAG_BASE(8'hF0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_ready(in_ready[0]), .tx_data(tx_data[0]), .tx_start(tx_start[0]),
      .tx_done(tx_done[0]), .cur_chan(cur_chan[0]), .busy(busy[0]));

   uart_tx_arbiter #(.N_PORTS(N), .CH_W(2), .TAG_ENABLE(1'b0), .TAG_BASE(8'hF0)) dut_nt (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_ready(in_ready[1]), .tx_data(tx_data[1]), .tx_start(tx_start[1]),
      .tx_done(tx_done[1]), .cur_chan(cur_chan[1]), .busy(busy[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_src(input int i, input int p, input logic [7:0] b);
      src_mem[i][p][src_wr[i][p]] = b;
      src_wr[i][p]++;
   endtask

   task automatic expect_b(input int i, input logic [7:0] b);
      exp_t x;
      x.inst = i;
      x.b    = b;
      exp_q.push_back(x);
   endtask

   task automatic pop_grant(input string tag, input int expg);
      if (gl.size() == 0) check({tag, "_missing"}, 32'hDEAD, 32'(expg));
      else                check(tag, 32'(gl.pop_front()), 32'(expg));
   endtask

   function automatic bit active();
      bit a = (exp_q.size() != 0) || busy[0] || busy[1] || mbusy[0] || mbusy[1];
      for (int i = 0; i < 2; i++)
         for (int p = 0; p < N; p++)
            if (src_rd[i][p] < src_wr[i][p]) a = 1'b1;
      return a;
   endfunction

   task automatic wait_idle(input string tag);
      int c = 0;
      while (active() && c < LIMIT) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_timeout"}, 32'(c < LIMIT), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   // Source feeder: each port presents its next queued byte until in_ready pops it.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (in_ready[i] !== '0) begin
            check($sformatf("in_ready_onehot_%0d", i), 32'($onehot(in_ready[i])), 32'd1);
            for (int p = 0; p < N; p++)
               if (in_ready[i][p]) begin
                  gl.push_back(i*16 + p);
                  if (src_rd[i][p] < src_wr[i][p]) src_rd[i][p]++;
               end
         end
         for (int p = 0; p < N; p++) begin
            if (src_rd[i][p] < src_wr[i][p]) begin
               in_valid[i][p]       = 1'b1;
               in_data[i][8*p +: 8] = src_mem[i][p][src_rd[i][p]];
            end else begin
               in_valid[i][p]       = 1'b0;
               in_data[i][8*p +: 8] = 8'h00;
            end
         end
      end
   end

   // uart_tx stand-in: done drops after start, rises again FRAME cycles later.
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            tx_done[i] <= 1'b1;
            mbusy[i]   <= 1'b0;
            cnt[i]     <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (tx_start[i]) begin
               nstart[i] <= nstart[i] + 1;
               check("start_while_frame_busy", 32'(mbusy[i]), 32'd0);
               if (exp_q.size() == 0) begin
                  check("unexpected_tx_byte", 32'(tx_data[i]), 32'h100);
               end else begin
                  e = exp_q.pop_front();
                  check("tx_inst", 32'(i), 32'(e.inst));
                  check("tx_byte", 32'(tx_data[i]), 32'(e.b));
               end
               mbusy[i]   <= 1'b1;
               cnt[i]     <= FRAME;
               tx_done[i] <= 1'b0;
            end else if (mbusy[i]) begin
               if (cnt[i] == 1) begin
                  check("busy_through_frame", 32'(busy[i]), 32'd1);
                  tx_done[i] <= 1'b1;
                  mbusy[i]   <= 1'b0;
               end else begin
                  cnt[i] <= cnt[i] - 1;
               end
            end
         end
      end
   end

   initial begin
      int c;
      nstart[0] = 0;
      nstart[1] = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready[0]), 32'd0);
      check("rst_tx_start", 32'(tx_start[0]), 32'd0);
      check("rst_tx_data",  32'(tx_data[0]),  32'd0);
      check("rst_cur_chan", 32'(cur_chan[0]), 32'd0);
      check("rst_busy",     32'(busy[0]),     32'd0);
      #2 rst = 1'b0;
      @(negedge clk);

      // Untagged instance, ports 0/1 alternating
      push_src(1, 0, 8'h55); push_src(1, 0, 8'h55);
      push_src(1, 1, 8'hAA); push_src(1, 1, 8'hAA);
      expect_b(1, 8'h55); expect_b(1, 8'hAA); expect_b(1, 8'h55); expect_b(1, 8'hAA);
      wait_idle("notag");
      pop_grant("notag_g0", 16); pop_grant("notag_g1", 17);
      pop_grant("notag_g2", 16); pop_grant("notag_g3", 17);
      check("notag_starts", 32'(nstart[1]), 32'd4);

      // Single byte from port 2 after reset: tagged
      push_src(0, 2, 8'h41);
      expect_b(0, 8'hF2); expect_b(0, 8'h41);
      wait_idle("t1");
      pop_grant("t1_grant", 2);
      check("t1_cur_chan", 32'(cur_chan[0]), 32'd2);
      check("t1_tx_data_hold", 32'(tx_data[0]), 32'h41);
      check("t1_busy_low", 32'(busy[0]), 32'd0);
      check("t1_starts", 32'(nstart[0]), 32'd2);

      // Same channel again: no tag
      push_src(0, 2, 8'h42);
      expect_b(0, 8'h42);
      wait_idle("t2");
      pop_grant("t2_grant", 2);
      check("t2_starts", 32'(nstart[0]), 32'd3);

      // Ports 0,1,3 together with rr_ptr=3
      push_src(0, 0, 8'h10); push_src(0, 1, 8'h11); push_src(0, 3, 8'h13);
      expect_b(0, 8'hF3); expect_b(0, 8'h13);
      expect_b(0, 8'hF0); expect_b(0, 8'h10);
      expect_b(0, 8'hF1); expect_b(0, 8'h11);
      wait_idle("t3");
      pop_grant("t3_g0", 3); pop_grant("t3_g1", 0); pop_grant("t3_g2", 1);
      check("t3_cur_chan", 32'(cur_chan[0]), 32'd1);

      // Port 0 held valid continuously alongside port 1
      for (int k = 0; k < 3; k++) begin
         push_src(0, 0, 8'(8'h20 + k));
         push_src(0, 1, 8'(8'h30 + k));
      end
      for (int k = 0; k < 3; k++) begin
         expect_b(0, 8'hF0); expect_b(0, 8'(8'h20 + k));
         expect_b(0, 8'hF1); expect_b(0, 8'(8'h30 + k));
      end
      wait_idle("t6");
      for (int k = 0; k < 6; k++) pop_grant($sformatf("t6_g%0d", k), k % 2);

      // Reset during the data frame's wait-high phase
      push_src(0, 1, 8'hB0);
      expect_b(0, 8'hB0);
      c = 0;
      while (tx_done[0] !== 1'b0 && c < LIMIT) begin
         @(negedge clk);
         c++;
      end
      check("t5_start_seen", 32'(c < LIMIT), 32'd1);
      repeat (20) @(negedge clk);
      check("t5_busy_before_rst", 32'(busy[0]), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_busy",     32'(busy[0]),     32'd0);
      check("t5_rst_tx_start", 32'(tx_start[0]), 32'd0);
      check("t5_rst_in_ready", 32'(in_ready[0]), 32'd0);
      check("t5_rst_tx_data",  32'(tx_data[0]),  32'd0);
      check("t5_rst_cur_chan", 32'(cur_chan[0]), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      pop_grant("t5_grant_b0", 1);

      // After reset: rr_ptr=0 and last_valid=0, so port 1 first and tagged
      push_src(0, 1, 8'hC0); push_src(0, 3, 8'hD3);
      expect_b(0, 8'hF1); expect_b(0, 8'hC0);
      expect_b(0, 8'hF3); expect_b(0, 8'hD3);
      wait_idle("t5b");
      pop_grant("t5b_g0", 1); pop_grant("t5b_g1", 3);

      check("left_grants", 32'(gl.size()), 32'd0);
      check("left_expected", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
